// File: rtl/countdown_timer_ctrl_if.sv
// Command and status bundle between the button/command logic and the countdown timer.
interface countdown_timer_ctrl_if;
  logic       start;
  logic       pause;
  logic       clear;
  logic [1:0] rate_sel;
  logic [7:0] load_val;
  logic       tick;
  logic [7:0] remaining;
  logic [1:0] state;
  logic       done;
  logic       busy;

  modport master (
    output start, pause, clear, rate_sel, load_val,
    input  tick, remaining, state, done, busy
  );

  modport slave (
    input  start, pause, clear, rate_sel, load_val,
    output tick, remaining, state, done, busy
  );
endinterface

// File: rtl/countdown_timer_ctrl.sv
// Clock-enable prescaler with a countdown on top: start/pause/resume/clear from
// one-cycle command pulses, one registered tick per prescaler wrap.
module countdown_timer_ctrl #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  countdown_timer_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, DONE = 2'd3} state_e;

  localparam logic [CNT_W-1:0] TC_1HZ   = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] TC_10HZ  = CNT_W'(CLK_HZ / 10 - 1);
  localparam logic [CNT_W-1:0] TC_100HZ = CNT_W'(CLK_HZ / 100 - 1);
  localparam logic [CNT_W-1:0] TC_1KHZ  = CNT_W'(CLK_HZ / 1000 - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0] tc_q, tc_d;
  logic [7:0]       rem_q, rem_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] sel_tc;

  always_comb begin
    case (bus.rate_sel)
      2'b00:   sel_tc = TC_1HZ;
      2'b01:   sel_tc = TC_10HZ;
      2'b10:   sel_tc = TC_100HZ;
      default: sel_tc = TC_1KHZ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      tc_q    <= TC_1HZ;
      rem_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tc_q    <= tc_d;
      rem_q   <= rem_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tc_d    = tc_q;
    rem_d   = rem_q;
    tick_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      presc_d = '0;
      rem_d   = '0;
    end else if (bus.start) begin
      if (state_q == PAUSE) begin
        state_d = RUN;
      end else begin
        tc_d    = sel_tc;
        presc_d = '0;
        rem_d   = bus.load_val;
        state_d = (bus.load_val == 8'd0) ? DONE : RUN;
      end
    end else if (state_q == RUN) begin
      // The prescaler still advances on a pause edge, so a coincident tick fires.
      if (presc_q == tc_q) begin
        presc_d = '0;
        tick_d  = 1'b1;
        rem_d   = rem_q - 8'd1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (tick_d && rem_q == 8'd1) state_d = DONE;
      else if (bus.pause)          state_d = PAUSE;
    end
  end

  assign bus.tick      = tick_q;
  assign bus.remaining = rem_q;
  assign bus.state     = state_q;
  assign bus.done      = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == PAUSE);

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl at CLK_HZ = 1000 (TC = 999/99/9/0).
module tb_countdown_timer_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  countdown_timer_ctrl_if bus();

  countdown_timer_ctrl #(.CLK_HZ(1000), .CNT_W(11)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd_start(input logic [1:0] rate, input logic [7:0] val);
    bus.rate_sel = rate;
    bus.load_val = val;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.rate_sel = 0; bus.load_val = 0;
    repeat (2) step();
    checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
    checks++; if (bus.remaining !== 8'd0) begin errors++; $display("FAIL reset_rem got=%0d exp=0", bus.remaining); end
    checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick got=%b exp=0", bus.tick); end
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL reset_done_busy got=%b%b exp=00", bus.done, bus.busy); end
    rst_n = 1'b1;
    step();
    checks++; if (bus.state !== 2'd0 || bus.tick !== 1'b0) begin errors++; $display("FAIL idle_after_release state=%0d tick=%b exp=0/0", bus.state, bus.tick); end
  endtask

  task automatic test_fast_rate();
    cmd_start(2'b11, 8'd3);
    checks++; if (bus.state !== 2'd1 || bus.remaining !== 8'd3 || bus.tick !== 1'b0) begin errors++; $display("FAIL fast_start state=%0d rem=%0d tick=%b exp=1/3/0", bus.state, bus.remaining, bus.tick); end
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (bus.tick !== 1'b1 || bus.remaining !== 8'(3 - i)) begin errors++; $display("FAIL fast_tick%0d tick=%b rem=%0d exp=1/%0d", i, bus.tick, bus.remaining, 3 - i); end
    end
    checks++; if (bus.done !== 1'b1 || bus.state !== 2'd3 || bus.busy !== 1'b0) begin errors++; $display("FAIL fast_done done=%b state=%0d busy=%b exp=1/3/0", bus.done, bus.state, bus.busy); end
    step();
    checks++; if (bus.tick !== 1'b0 || bus.remaining !== 8'd0 || bus.state !== 2'd3) begin errors++; $display("FAIL fast_hold tick=%b rem=%0d state=%0d exp=0/0/3", bus.tick, bus.remaining, bus.state); end
  endtask

  task automatic test_slow_rate();
    int n = 0, t1 = -1, t2 = -1;
    logic done_at_t2 = 1'b0, busy_at_t2 = 1'b1;
    cmd_start(2'b00, 8'd2);
    while (n < 2500 && t2 < 0) begin
      step();
      n++;
      if (bus.tick === 1'b1) begin
        if (t1 < 0) t1 = n;
        else begin t2 = n; done_at_t2 = bus.done; busy_at_t2 = bus.busy; end
      end
    end
    checks++; if (t1 != 1000) begin errors++; $display("FAIL slow_tick1 got=%0d exp=1000", t1); end
    checks++; if (t2 != 2000) begin errors++; $display("FAIL slow_tick2 got=%0d exp=2000", t2); end
    checks++; if (done_at_t2 !== 1'b1 || busy_at_t2 !== 1'b0) begin errors++; $display("FAIL slow_done done=%b busy=%b exp=1/0", done_at_t2, busy_at_t2); end
  endtask

  task automatic test_pause_resume();
    int n = 0;
    logic held_ok = 1'b1;
    cmd_start(2'b01, 8'd5);
    repeat (39) step();
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    checks++; if (bus.state !== 2'd2 || bus.busy !== 1'b1) begin errors++; $display("FAIL pause_enter state=%0d busy=%b exp=2/1", bus.state, bus.busy); end
    repeat (500) begin
      step();
      if (bus.remaining !== 8'd5 || bus.tick !== 1'b0 || bus.state !== 2'd2) held_ok = 1'b0;
    end
    checks++; if (!held_ok) begin errors++; $display("FAIL pause_hold got=frozen_violated exp=rem5_no_tick"); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.state !== 2'd1 || bus.remaining !== 8'd5) begin errors++; $display("FAIL resume state=%0d rem=%0d exp=1/5", bus.state, bus.remaining); end
    while (n < 200 && bus.tick !== 1'b1) begin step(); n++; end
    checks++; if (n != 60) begin errors++; $display("FAIL resume_tick_delay got=%0d exp=60", n); end
    checks++; if (bus.remaining !== 8'd4) begin errors++; $display("FAIL resume_rem got=%0d exp=4", bus.remaining); end
  endtask

  task automatic test_simultaneous();
    cmd_start(2'b11, 8'd9);
    step();
    bus.clear = 1'b1; bus.start = 1'b1;
    step();
    bus.clear = 1'b0; bus.start = 1'b0;
    checks++; if (bus.state !== 2'd0 || bus.remaining !== 8'd0) begin errors++; $display("FAIL clear_start state=%0d rem=%0d exp=0/0", bus.state, bus.remaining); end
    cmd_start(2'b11, 8'd1);
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    checks++; if (bus.state !== 2'd3 || bus.tick !== 1'b1 || bus.remaining !== 8'd0 || bus.done !== 1'b1) begin errors++; $display("FAIL pause_final_tick state=%0d tick=%b rem=%0d exp=3/1/0", bus.state, bus.tick, bus.remaining); end
    cmd_start(2'b11, 8'd3);
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    checks++; if (bus.state !== 2'd2 || bus.tick !== 1'b1 || bus.remaining !== 8'd2) begin errors++; $display("FAIL pause_on_tick state=%0d tick=%b rem=%0d exp=2/1/2", bus.state, bus.tick, bus.remaining); end
    bus.load_val = 8'd50;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.state !== 2'd1 || bus.remaining !== 8'd2) begin errors++; $display("FAIL resume_no_reload state=%0d rem=%0d exp=1/2", bus.state, bus.remaining); end
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.state !== 2'd0 || bus.remaining !== 8'd0 || bus.busy !== 1'b0) begin errors++; $display("FAIL clear_pause state=%0d rem=%0d exp=0/0", bus.state, bus.remaining); end
    cmd_start(2'b11, 8'd0);
    checks++; if (bus.state !== 2'd3 || bus.done !== 1'b1 || bus.remaining !== 8'd0) begin errors++; $display("FAIL start_zero state=%0d done=%b rem=%0d exp=3/1/0", bus.state, bus.done, bus.remaining); end
  endtask

  task automatic test_mid_reset();
    logic quiet = 1'b1;
    cmd_start(2'b01, 8'd7);
    repeat (10) step();
    checks++; if (bus.remaining !== 8'd7 || bus.state !== 2'd1) begin errors++; $display("FAIL pre_reset rem=%0d state=%0d exp=7/1", bus.remaining, bus.state); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.state !== 2'd0 || bus.remaining !== 8'd0 || bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL async_reset state=%0d rem=%0d tick=%b done=%b busy=%b exp=0/0/0/0/0", bus.state, bus.remaining, bus.tick, bus.done, bus.busy);
    end
    step();
    rst_n = 1'b1;
    repeat (300) begin
      step();
      if (bus.tick !== 1'b0 || bus.state !== 2'd0) quiet = 1'b0;
    end
    checks++; if (!quiet) begin errors++; $display("FAIL post_reset_quiet got=activity exp=idle_no_tick"); end
  endtask

  task automatic test_rate_latch();
    int n = 0;
    logic fast_ok = 1'b1;
    cmd_start(2'b11, 8'd4);
    bus.rate_sel = 2'b00;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (bus.tick !== 1'b1 || bus.remaining !== 8'(4 - i)) fast_ok = 1'b0;
    end
    checks++; if (!fast_ok || bus.state !== 2'd3) begin errors++; $display("FAIL rate_latch_fast ok=%b state=%0d exp=1/3", fast_ok, bus.state); end
    cmd_start(2'b00, 8'd1);
    while (n < 1500 && bus.tick !== 1'b1) begin step(); n++; end
    checks++; if (n != 1000) begin errors++; $display("FAIL rate_latch_restart got=%0d exp=1000", n); end
  endtask

  initial begin
    test_reset();
    test_fast_rate();
    test_slow_rate();
    test_pause_resume();
    test_simultaneous();
    test_mid_reset();
    test_rate_latch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer_ctrl.md
# countdown_timer_ctrl

Controller that owns a clock-enable prescaler and runs a countdown timer on top of it. The prescaler is started, paused, resumed and cleared from one-cycle command pulses. It emits a single-cycle `tick` enable at a selectable rate and decrements a loaded count on each tick. It sits between the debounced button/command logic and the display datapath. All timing uses clock enables on `clk`; no derived clocks are generated.

## Interface
- `CLK_HZ`, default 100_000_000: input clock frequency. Must be a multiple of 1000 and ≥ 1000.
- `CNT_W`, default 27: prescaler width. Must satisfy 2^CNT_W > CLK_HZ.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: one-cycle pulse. Starts or restarts from IDLE/DONE; resumes from PAUSE.
- `pause` input, 1 bit: one-cycle pulse. Freezes a running countdown.
- `clear` input, 1 bit: one-cycle pulse. Aborts to IDLE.
- `rate_sel` input, 2 bits: tick rate. 00 = 1 Hz, 01 = 10 Hz, 10 = 100 Hz, 11 = 1 kHz.
- `load_val` input, 8 bits: count loaded on start from IDLE/DONE.
- `tick` output, 1 bit: registered one-cycle enable pulse at the selected rate.
- `remaining` output, 8 bits: current count.
- `state` output, 2 bits: IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3.
- `done` output, 1 bit: level, high exactly while in DONE.
- `busy` output, 1 bit: level, high while in RUN or PAUSE.

## Operation
- Terminal count TC = CLK_HZ / rate − 1. For CLK_HZ = 100 MHz: 99_999_999, 9_999_999, 999_999, 99_999.
- `rate_sel` and `load_val` are sampled only on a start from IDLE/DONE. Changes mid-run are ignored; the latched TC holds until the next such start.
- Command priority, evaluated each edge: `clear` > `start` > `pause`.
- **IDLE**
  - `start` with `load_val` ≠ 0: latch TC, set `remaining` = `load_val`, set prescaler = 0, go to RUN.
  - `start` with `load_val` = 0: go directly to DONE with `remaining` = 0.
  - `pause` and `clear` have no effect.
- **RUN**
  - Each edge: if prescaler == TC, set prescaler = 0, `tick` = 1 and `remaining` = `remaining` − 1. Otherwise prescaler + 1 and `tick` = 0.
  - A tick that takes `remaining` from 1 to 0 also moves to DONE on the same edge.
  - `pause`: go to PAUSE and hold the prescaler.
  - `clear`: go to IDLE.
  - `start`: restart. Reload `load_val`, relatch TC, prescaler = 0.
- **PAUSE**
  - Prescaler, `remaining` and TC are frozen; `tick` = 0.
  - `start`: return to RUN and continue from the held prescaler value. No reload.
  - `clear`: go to IDLE.
  - `pause`: ignored.
- **DONE**
  - `remaining` = 0, `done` = 1.
  - `start`: reload and enter RUN, as from IDLE.
  - `clear`: go to IDLE.
- Clearing to IDLE sets `remaining` = 0 and prescaler = 0.
- Pause and tick coincide on one edge: the tick still fires and decrements, then the block enters PAUSE. If that decrement reaches 0, DONE wins over PAUSE.
- `remaining` never wraps below 0. No decrement occurs outside RUN.

## Timing
- Reset values: state = IDLE, `remaining` = 0, prescaler = 0, TC = 1 Hz value, `tick` = 0, `done` = 0, `busy` = 0.
- Reset is asynchronous and may arrive mid-RUN or mid-PAUSE. All outputs return to their reset values immediately.
- All outputs are registered and update on the same edge that samples a command.
- Start sampled at edge N: `state` and `remaining` are valid after edge N.
- First `tick` is high after edge N + TC + 1; ticks then repeat every TC + 1 cycles exactly.
- For TC = 0, `tick` is high every cycle in RUN.
- Resume after pause: the next tick arrives after TC − p + 1 RUN cycles, where p is the held prescaler value.
- The final tick and the DONE entry occur on the same edge. `done` rises in the same cycle as the final `tick`.

## Test plan
- **Fast rate.** CLK_HZ = 1000, `rate_sel` = 11, `load_val` = 3, start at cycle 0.
  - `tick` is high in cycles 1, 2 and 3.
  - `remaining` reads 3, 2, 1, 0.
  - `done` = 1 from cycle 3; `state` = 3.
- **1 Hz sim rate.** CLK_HZ = 1000, `rate_sel` = 00, `load_val` = 2.
  - Ticks after exactly 1000 and 2000 cycles.
  - `busy` falls and `done` rises with the second tick.
- **Pause/resume.** CLK_HZ = 1000, `rate_sel` = 01 (TC = 99), `load_val` = 5.
  - Pause 40 cycles after start, hold 500 cycles, then resume.
  - Next tick arrives 60 cycles after the resume edge; `remaining` stays 5 throughout the pause.
- **Simultaneous commands.** Assert `clear` + `start` in RUN: go to IDLE, `remaining` = 0.
  - `pause` on a tick edge with `remaining` = 1: block enters DONE, not PAUSE.
  - `start` with `load_val` = 0: DONE on the next edge.
- **Mid-run reset.** Assert `rst_n` = 0 asynchronously mid-RUN with `remaining` = 7.
  - All outputs reach their reset values before the next edge.
  - After release, no `tick` appears until a new start.
- **Rate latch.** Change `rate_sel` from 11 to 00 mid-RUN.
  - Tick period stays 1 cycle until DONE.
  - Restart then uses a 1000-cycle period.
